// File: rtl/vga_pattern_generator.sv
// rtl/vga_pattern_generator.sv - two-stage VGA test pattern pixel stage; optional bouncing box overlay when PATTERN_BOX_EN is defined
module vga_pattern_generator #(
  parameter int                      COUNTER_SIZE    = 11,
  parameter logic [COUNTER_SIZE-1:0] THRESHOLD_HSYNC = 11'd1024,
  parameter logic [COUNTER_SIZE-1:0] THRESHOLD_VSYNC = 11'd768,
  parameter int                      PIPE_DEPTH      = 2
) (
  input  logic                    control_clock,
  input  logic                    control_reset,
  input  logic [COUNTER_SIZE-1:0] counter_in_hsync,
  input  logic [COUNTER_SIZE-1:0] counter_in_vsync,
  input  logic                    h_sync_in,
  input  logic                    v_sync_in,
  input  logic [1:0]              pattern_sel,
  output logic [3:0]              red,
  output logic [3:0]              green,
  output logic [3:0]              blue,
  output logic                    h_sync_out,
  output logic                    v_sync_out,
  output logic                    active_video,
  output logic [7:0]              frame_count
);

  // Only counter bits [9:5] feed the patterns; the box overlay needs full 10-bit coordinates.
`ifdef PATTERN_BOX_EN
  localparam int CLO = 0;
`else
  localparam int CLO = 5;
`endif

  // Stage 1 registers
  logic [9:CLO]          r_h1;
  logic [9:CLO]          r_v1;
  logic                  r_act1;
  logic [PIPE_DEPTH-1:0] r_hs_pipe;
  logic [PIPE_DEPTH-1:0] r_vs_pipe;

  // Frame-level state
  logic [1:0]            r_pattern_cur;
  logic [7:0]            r_frame_count;

  // Stage 2 registers
  logic [3:0]            r_red;
  logic [3:0]            r_green;
  logic [3:0]            r_blue;
  logic                  r_active;

  // Combinational helpers
  logic                  w_fs;
  logic                  w_act0;
  logic [2:0]            w_bar_idx;
  logic [11:0]           w_rgb;
  logic [11:0]           w_pix;

  assign w_fs   = (counter_in_hsync == '0) && (counter_in_vsync == '0);
  assign w_act0 = (counter_in_hsync < THRESHOLD_HSYNC) && (counter_in_vsync < THRESHOLD_VSYNC);

  // Stage 1: capture counters, visibility flag and syncs
  always_ff @(posedge control_clock) begin
    if (control_reset) begin
      r_h1      <= '0;
      r_v1      <= '0;
      r_act1    <= 1'b0;
      r_hs_pipe <= '0;
      r_vs_pipe <= '0;
    end else begin
      r_h1      <= counter_in_hsync[9:CLO];
      r_v1      <= counter_in_vsync[9:CLO];
      r_act1    <= w_act0;
      r_hs_pipe <= {r_hs_pipe[PIPE_DEPTH-2:0], h_sync_in};
      r_vs_pipe <= {r_vs_pipe[PIPE_DEPTH-2:0], v_sync_in};
    end
  end

  // Frame start: latch the requested pattern and count the frame; the (0,0) pixel
  // reaches stage 2 one edge later and therefore already sees the new values
  always_ff @(posedge control_clock) begin
    if (control_reset) begin
      r_pattern_cur <= 2'd0;
      r_frame_count <= 8'd0;
    end else if (w_fs) begin
      r_pattern_cur <= pattern_sel;
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign w_bar_idx = r_h1[9:7];

  // Pattern colour from stage-1 coordinates
  always_comb begin
    w_rgb = 12'h000;
    case (r_pattern_cur)
      2'd0: w_rgb = {{4{w_bar_idx[2]}}, {4{w_bar_idx[1]}}, {4{w_bar_idx[0]}}};
      2'd1: w_rgb = (r_h1[5] ^ r_v1[5]) ? 12'hFFF : 12'h000;
      2'd2: w_rgb = {r_h1[9:6], r_v1[9:6], r_frame_count[3:0]};
      default: w_rgb = 12'hFFF;
    endcase
  end

`ifdef PATTERN_BOX_EN
  localparam logic [9:0] BOX_X_MAX = 10'(THRESHOLD_HSYNC - 16);
  localparam logic [9:0] BOX_Y_MAX = 10'(THRESHOLD_VSYNC - 16);

  logic [9:0] r_box_x;
  logic [9:0] r_box_y;
  logic       r_dir_x;  // 1 = moving towards larger coordinates
  logic       r_dir_y;
  logic       w_box_hit;

  // Bounce the box one pixel per axis on each frame start, reversing at the edges
  always_ff @(posedge control_clock) begin
    if (control_reset) begin
      r_box_x <= 10'd0;
      r_box_y <= 10'd0;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else if (w_fs) begin
      if (r_dir_x) begin
        if (r_box_x == BOX_X_MAX) begin
          r_dir_x <= 1'b0;
          r_box_x <= r_box_x - 10'd1;
        end else begin
          r_box_x <= r_box_x + 10'd1;
        end
      end else begin
        if (r_box_x == 10'd0) begin
          r_dir_x <= 1'b1;
          r_box_x <= r_box_x + 10'd1;
        end else begin
          r_box_x <= r_box_x - 10'd1;
        end
      end
      if (r_dir_y) begin
        if (r_box_y == BOX_Y_MAX) begin
          r_dir_y <= 1'b0;
          r_box_y <= r_box_y - 10'd1;
        end else begin
          r_box_y <= r_box_y + 10'd1;
        end
      end else begin
        if (r_box_y == 10'd0) begin
          r_dir_y <= 1'b1;
          r_box_y <= r_box_y + 10'd1;
        end else begin
          r_box_y <= r_box_y - 10'd1;
        end
      end
    end
  end

  // 11-bit compare so box_x+16 cannot wrap
  assign w_box_hit = ({1'b0, r_h1} >= {1'b0, r_box_x}) &&
                     ({1'b0, r_h1} <  ({1'b0, r_box_x} + 11'd16)) &&
                     ({1'b0, r_v1} >= {1'b0, r_box_y}) &&
                     ({1'b0, r_v1} <  ({1'b0, r_box_y} + 11'd16));
  assign w_pix = w_box_hit ? 12'hFF0 : w_rgb;
`else
  assign w_pix = w_rgb;
`endif

  // Stage 2: register colour with blanking applied outside the visible region
  always_ff @(posedge control_clock) begin
    if (control_reset) begin
      r_red    <= 4'h0;
      r_green  <= 4'h0;
      r_blue   <= 4'h0;
      r_active <= 1'b0;
    end else if (r_act1) begin
      {r_red, r_green, r_blue} <= w_pix;
      r_active <= 1'b1;
    end else begin
      {r_red, r_green, r_blue} <= 12'h000;
      r_active <= 1'b0;
    end
  end

  assign red          = r_red;
  assign green        = r_green;
  assign blue         = r_blue;
  assign active_video = r_active;
  assign h_sync_out   = r_hs_pipe[PIPE_DEPTH-1];
  assign v_sync_out   = r_vs_pipe[PIPE_DEPTH-1];
  assign frame_count  = r_frame_count;

endmodule
